// File: rtl/divsqrt_issue_pkg.sv
// Shared cvw package: issue-FSM state encoding and the held op-control bundle
// used by the divide/sqrt issue block.
package cvw;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } divState_t;

   typedef struct packed {
      logic       isInt;
      logic       isSqrt;
      logic       isW64;
      logic [2:0] funct3;
   } opCtl_t;

endpackage

// File: rtl/divsqrt_issue_wdog.sv
// WAIT-state watchdog for divsqrt_issue; only built when DIVSQRT_ISSUE_TIMEOUT_EN
// is defined. Counts WAIT cycles and flags expiry on the TMO_CYCLES-th one.
module divsqrt_issue_wdog #(
   parameter int TMO_CYCLES = 128
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int CW = $clog2(TMO_CYCLES + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                  cnt <= '0;
      else if (clear)              cnt <= '0;
      else if (run && !expired)    cnt <= cnt + 1'b1;
   end

   // Fires during the last permitted WAIT cycle so the edge closing it leaves WAIT.
   assign expired = run && (cnt == CW'(TMO_CYCLES - 1));

endmodule

// File: rtl/divsqrt_issue.sv
// Issue/response sequencer between a request port and a multi-cycle div/sqrt unit.
// Optional watchdog timeout enabled by defining DIVSQRT_ISSUE_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | one-cycle start pulse to the divider
// WAIT  | divider running, waiting for div_done (or timeout)
// RESP  | response held until rsp_ready
module divsqrt_issue import cvw::*; #(
   parameter int XLEN       = 64,
   parameter int TMO_CYCLES = 128
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_int,
   input  logic            req_sqrt,
   input  logic            req_w64,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   output logic            start_f,
   output logic            start_i,
   output logic            op_int,
   output logic            op_sqrt,
   output logic            op_w64,
   output logic [2:0]      op_funct3,
   output logic [XLEN-1:0] op_a,
   output logic [XLEN-1:0] op_b,
   input  logic            div_busy,
   input  logic            div_done,
   input  logic [XLEN-1:0] div_result,
   input  logic            flush,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_result,
   output logic            rsp_err
);

   divState_t state, stateNext;
   opCtl_t    opCtl;
   logic      accept;
   logic      tmoHit;
   logic      waitEnd;

   if (TMO_CYCLES < 1) begin : gBadTmo
      $error("TMO_CYCLES must be at least 1");
   end

   assign accept  = (state == IDLE) && req_valid;
   assign waitEnd = (state == WAIT) && !flush && (div_done || tmoHit);

`ifdef DIVSQRT_ISSUE_TIMEOUT_EN
   divsqrt_issue_wdog #(.TMO_CYCLES(TMO_CYCLES)) uWdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (state == ISSUE),
      .run     (state == WAIT),
      .expired (tmoHit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       rsp_err <= 1'b0;
      else if (waitEnd) rsp_err <= !div_done;
   end
`else
   assign tmoHit  = 1'b0;
   assign rsp_err = 1'b0;
`endif

   always_comb begin
      stateNext = state;
      req_ready = 1'b0;
      start_f   = 1'b0;
      start_i   = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) stateNext = ISSUE;
         end
         ISSUE: begin
            if (flush) stateNext = IDLE;
            else begin
               start_i   = opCtl.isInt;
               start_f   = !opCtl.isInt;
               stateNext = WAIT;
            end
         end
         WAIT: begin
            if (flush)                    stateNext = IDLE;
            else if (div_done || tmoHit)  stateNext = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         opCtl      <= '0;
         op_a       <= '0;
         op_b       <= '0;
         rsp_result <= '0;
      end else begin
         state <= stateNext;
         if (accept) begin
            opCtl <= '{isInt: req_int, isSqrt: req_sqrt, isW64: req_w64, funct3: req_funct3};
            op_a  <= req_a;
            op_b  <= req_b;
         end
         // A timeout returns an all-zero result alongside rsp_err.
         if (waitEnd) rsp_result <= div_done ? div_result : '0;
      end
   end

   assign op_int    = opCtl.isInt;
   assign op_sqrt   = opCtl.isSqrt;
   assign op_w64    = opCtl.isW64;
   assign op_funct3 = opCtl.funct3;

   aBusyInWait: assert property (@(posedge clk) disable iff (!reset)
      (state == WAIT) |-> div_busy);

endmodule

// File: tb/tb_divsqrt_issue.sv
// Directed bench for divsqrt_issue; the timeout scenario runs only when
// DIVSQRT_ISSUE_TIMEOUT_EN is defined (TMO_CYCLES=8), otherwise WAIT must persist.
module tb_divsqrt_issue;

   localparam int XLEN = 64;

   logic            clk, reset;
   logic            req_valid, req_ready, req_int, req_sqrt, req_w64;
   logic [2:0]      req_funct3;
   logic [XLEN-1:0] req_a, req_b;
   logic            start_f, start_i, op_int, op_sqrt, op_w64;
   logic [2:0]      op_funct3;
   logic [XLEN-1:0] op_a, op_b;
   logic            div_busy, div_done;
   logic [XLEN-1:0] div_result;
   logic            flush, rsp_valid, rsp_ready, rsp_err;
   logic [XLEN-1:0] rsp_result;

   int nChecks = 0;
   int nFails  = 0;

   divsqrt_issue #(.XLEN(XLEN), .TMO_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_int(req_int),
      .req_sqrt(req_sqrt), .req_w64(req_w64), .req_funct3(req_funct3),
      .req_a(req_a), .req_b(req_b),
      .start_f(start_f), .start_i(start_i),
      .op_int(op_int), .op_sqrt(op_sqrt), .op_w64(op_w64), .op_funct3(op_funct3),
      .op_a(op_a), .op_b(op_b),
      .div_busy(div_busy), .div_done(div_done), .div_result(div_result),
      .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_err(rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL global_timeout observed=stuck expected=finish");
      $fatal(1, "bench time limit reached");
   end

   task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sendReq(input logic isInt, input logic isSqrt, input logic [2:0] f3,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      req_valid  = 1'b1;
      req_int    = isInt;
      req_sqrt   = isSqrt;
      req_w64    = 1'b0;
      req_funct3 = f3;
      req_a      = a;
      req_b      = b;
   endtask

   int startCyc[8];
   int nStarts, nRsp, cyc, extraStarts, waitCnt;
   logic pend, s;

   initial begin
      reset = 1'b0; req_valid = 0; req_int = 0; req_sqrt = 0; req_w64 = 0;
      req_funct3 = '0; req_a = '0; req_b = '0; div_busy = 0; div_done = 0;
      div_result = '0; flush = 0; rsp_ready = 1;
      tick(); tick();
      check("rst_req_ready", req_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_starts", {start_f, start_i}, 0);
      check("rst_op_a", op_a, 0);
      check("rst_rsp_result", rsp_result, 0);
      check("rst_rsp_err", rsp_err, 0);
      reset = 1'b1;
      tick();

      // integer op 100/7, divider answers 14 on the 10th cycle after start
      sendReq(1, 0, 3'b100, 64'd100, 64'd7);
      tick();
      req_valid = 0; div_busy = 1;
      #1;
      check("int_start_i", start_i, 1);
      check("int_start_f", start_f, 0);
      check("int_op_a", op_a, 100);
      check("int_op_b", op_b, 7);
      check("int_op_funct3", op_funct3, 3'b100);
      check("int_op_int", op_int, 1);
      check("int_req_ready", req_ready, 0);
      extraStarts = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (start_i || start_f || rsp_valid) extraStarts++;
      end
      check("int_no_extra_pulse", extraStarts, 0);
      div_done = 1; div_result = 64'd14;
      tick();
      div_done = 0; div_busy = 0; div_result = 64'd99;
      check("int_rsp_valid", rsp_valid, 1);
      check("int_rsp_result", rsp_result, 14);
      check("int_rsp_err", rsp_err, 0);
      tick();
      check("int_back_idle", {rsp_valid, req_ready}, 2'b01);

      // FP sqrt with a stalled consumer; done during ISSUE must be ignored
      rsp_ready = 0;
      sendReq(0, 1, 3'b000, 64'h4010_0000_0000_0000, 64'd0);
      tick();
      req_valid = 0; div_busy = 1; div_done = 1; div_result = 64'hBAD;
      #1;
      check("sqrt_start_f", start_f, 1);
      check("sqrt_start_i", start_i, 0);
      check("sqrt_op_sqrt", op_sqrt, 1);
      tick();
      div_done = 0;
      check("sqrt_done_in_issue_ignored", rsp_valid, 0);
      div_done = 1; div_result = 64'h4000_0000_0000_0000;
      tick();
      div_done = 0; div_busy = 0; div_result = 64'd0;
      sendReq(1, 0, 3'b101, 64'd555, 64'd5);
      for (int i = 0; i < 5; i++) begin
         flush = (i == 2);
         check("sqrt_stall_valid", rsp_valid, 1);
         check("sqrt_stall_result", rsp_result, 64'h4000_0000_0000_0000);
         check("sqrt_stall_req_ready", req_ready, 0);
         tick();
      end
      flush = 0;
      check("sqrt_op_a_held", op_a, 64'h4010_0000_0000_0000);
      req_valid = 0; rsp_ready = 1;
      tick();
      check("sqrt_back_idle", {rsp_valid, req_ready}, 2'b01);

      // flush in the 3rd WAIT cycle, late done, then a clean follow-up op
      sendReq(1, 0, 3'b100, 64'd50, 64'd5);
      tick();
      req_valid = 0; div_busy = 1;
      tick(); tick(); tick();
      flush = 1;
      tick();
      flush = 0;
      check("flush_wait_idle", {rsp_valid, req_ready}, 2'b01);
      div_done = 1; div_result = 64'hDEAD;
      tick();
      div_done = 0; div_busy = 0;
      check("flush_late_done_no_rsp", {rsp_valid, req_ready}, 2'b01);
      sendReq(1, 0, 3'b100, 64'd81, 64'd9);
      tick();
      req_valid = 0; div_busy = 1;
      #1;
      check("flush_next_start_i", start_i, 1);
      tick();
      div_done = 1; div_result = 64'd9;
      tick();
      div_done = 0; div_busy = 0;
      check("flush_next_rsp", {rsp_valid, rsp_result[7:0]}, 9'h109);
      tick();

      // flush during ISSUE suppresses the start pulse
      sendReq(1, 0, 3'b110, 64'd3, 64'd2);
      tick();
      req_valid = 0; flush = 1;
      #1;
      check("flush_issue_no_start", {start_f, start_i}, 2'b00);
      tick();
      flush = 0;
      check("flush_issue_idle", req_ready, 1);

      // asynchronous reset while in RESP
      rsp_ready = 0;
      sendReq(1, 0, 3'b100, 64'd20, 64'd4);
      tick();
      req_valid = 0; div_busy = 1;
      tick();
      div_done = 1; div_result = 64'd5;
      tick();
      div_done = 0; div_busy = 0;
      check("rstmid_in_resp", rsp_valid, 1);
      #1 reset = 1'b0;
      #1;
      check("rstmid_rsp_valid", rsp_valid, 0);
      check("rstmid_req_ready", req_ready, 1);
      check("rstmid_rsp_result", rsp_result, 0);
      check("rstmid_op_a", op_a, 0);
      tick();
      reset = 1'b1; rsp_ready = 1;
      tick();
      check("rstmid_no_rsp_after", rsp_valid, 0);

      // watchdog: divider never finishes
      sendReq(1, 0, 3'b100, 64'd1, 64'd1);
      tick();
      req_valid = 0; div_busy = 1;
`ifdef DIVSQRT_ISSUE_TIMEOUT_EN
      waitCnt = 0;
      while (!rsp_valid && waitCnt < 30) begin
         tick();
         waitCnt++;
      end
      div_busy = 0;
      check("tmo_latency", waitCnt, 9);
      check("tmo_rsp_err", rsp_err, 1);
      check("tmo_rsp_result", rsp_result, 0);
      tick();
`else
      for (int i = 0; i < 20; i++) tick();
      check("notmo_still_waiting", {rsp_valid, req_ready, rsp_err}, 3'b000);
      flush = 1;
      tick();
      flush = 0; div_busy = 0;
      check("notmo_flushed", req_ready, 1);
`endif

      // back-to-back with a one-cycle divider
      rsp_ready = 1;
      sendReq(1, 0, 3'b100, 64'd64, 64'd8);
      nStarts = 0; nRsp = 0; cyc = 0; pend = 0;
      for (int k = 0; k < 14; k++) begin
         tick();
         cyc++;
         s = start_i | start_f;
         if (rsp_valid) nRsp++;
         div_done = pend; div_busy = pend; div_result = 64'd8;
         if (s && nStarts < 8) begin
            startCyc[nStarts] = cyc;
            nStarts++;
         end
         pend = s;
      end
      req_valid = 0;
      tick();
      div_done = 0; div_busy = 0;
      tick();
      check("b2b_start_count", nStarts, 4);
      check("b2b_rsp_count", nRsp, 3);
      check("b2b_first_start", startCyc[0], 1);
      for (int k = 1; k < 4; k++)
         check("b2b_interval", startCyc[k] - startCyc[k-1], 4);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
